// File: rtl/z80_fetch_sequencer.sv
// Z80 instruction fetch sequencer: reads bytes until the external decoder reports a complete instruction.
// Optional macro FETCH_TIMEOUT_EN aborts a memory read after TIMEOUT_CYCLES cycles without mem_ready.
`ifndef INSN_GROUP_NEED_MORE_BYTES
`define INSN_GROUP_NEED_MORE_BYTES 8'hFE
`endif
`ifndef INSN_GROUP_ILLEGAL_INSTR
`define INSN_GROUP_ILLEGAL_INSTR 8'hFF
`endif

module z80_fetch_sequencer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pc_in,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready,
  output logic [31:0] dec_instr,
  output logic [1:0]  dec_op_len,
  input  logic [2:0]  dec_len,
  input  logic [7:0]  dec_group,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] instr_out,
  output logic [2:0]  instr_len,
  output logic [7:0]  group_out,
  output logic [15:0] next_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [2:0]  byte_cnt_reg, byte_cnt_next;
  logic        opcode_phase_reg, opcode_phase_next;
  logic [1:0]  op_len_reg, op_len_next;
  logic [31:0] buf_reg, buf_next;
  logic [2:0]  len_reg, len_next;
  logic [7:0]  group_reg, group_next;
  logic [15:0] npc_reg, npc_next;
  logic        illegal_reg, illegal_next;
  logic [31:0] lane_data;
  logic [15:0] cur_addr;
  logic        finish;

  generate
    if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 255) begin : g_bad_param
      $error("TIMEOUT_CYCLES must be in 4..255");
    end
  endgenerate

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       timeout_reg, timeout_next;
`endif

  // Buffer image with the incoming byte merged into lane byte_cnt.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_data[gi*8 +: 8] = (byte_cnt_reg[1:0] == 2'(gi)) ? mem_data : buf_reg[gi*8 +: 8];
    end
  endgenerate

  assign cur_addr = pc_reg + {13'd0, byte_cnt_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      pc_reg           <= '0;
      byte_cnt_reg     <= '0;
      opcode_phase_reg <= 1'b0;
      op_len_reg       <= '0;
      buf_reg          <= '0;
      len_reg          <= '0;
      group_reg        <= '0;
      npc_reg          <= '0;
      illegal_reg      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_reg     <= '0;
      timeout_reg      <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      byte_cnt_reg     <= byte_cnt_next;
      opcode_phase_reg <= opcode_phase_next;
      op_len_reg       <= op_len_next;
      buf_reg          <= buf_next;
      len_reg          <= len_next;
      group_reg        <= group_next;
      npc_reg          <= npc_next;
      illegal_reg      <= illegal_next;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_reg     <= wait_cnt_next;
      timeout_reg      <= timeout_next;
`endif
    end
  end

  always_comb begin
    state_next        = state_reg;
    pc_next           = pc_reg;
    byte_cnt_next     = byte_cnt_reg;
    opcode_phase_next = opcode_phase_reg;
    op_len_next       = op_len_reg;
    buf_next          = buf_reg;
    len_next          = len_reg;
    group_next        = group_reg;
    npc_next          = npc_reg;
    illegal_next      = illegal_reg;
    finish            = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_next     = wait_cnt_reg;
    timeout_next      = timeout_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          pc_next           = pc_in;
          buf_next          = '0;
          byte_cnt_next     = '0;
          op_len_next       = '0;
          opcode_phase_next = 1'b1;
          illegal_next      = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_next     = '0;
          timeout_next      = 1'b0;
`endif
          state_next        = FETCH;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          buf_next      = lane_data;
          byte_cnt_next = byte_cnt_reg + 3'd1;
          if (opcode_phase_reg)
            op_len_next = op_len_reg + 2'd1;
          state_next    = CHECK;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_cnt_reg == TMO_LAST) begin
          timeout_next = 1'b1;
          illegal_next = 1'b0;
          group_next   = `INSN_GROUP_ILLEGAL_INSTR;
          len_next     = byte_cnt_reg;
          npc_next     = cur_addr;
          state_next   = DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
`endif
      end
      CHECK: begin
        if (dec_group == `INSN_GROUP_NEED_MORE_BYTES) begin
          if (op_len_reg < 2'd2) begin
            state_next = FETCH;
          end else begin
            illegal_next = 1'b1;
            finish       = 1'b1;
          end
        end else if (dec_group == `INSN_GROUP_ILLEGAL_INSTR) begin
          illegal_next = 1'b1;
          finish       = 1'b1;
        end else begin
          opcode_phase_next = 1'b0;
          // Buffer holds at most four bytes regardless of what the decoder asks for.
          if (byte_cnt_reg < dec_len && byte_cnt_reg < 3'd4)
            state_next = FETCH;
          else
            finish = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        if (state_next == FETCH)
          wait_cnt_next = '0;
`endif
        if (finish) begin
          group_next = dec_group;
          len_next   = byte_cnt_reg;
          npc_next   = cur_addr;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_rd     = (state_reg == FETCH);
  assign mem_addr   = (state_reg == FETCH) ? cur_addr : 16'd0;
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign dec_instr  = buf_reg;
  assign dec_op_len = op_len_reg;
  assign instr_out  = buf_reg;
  assign instr_len  = len_reg;
  assign group_out  = group_reg;
  assign next_pc    = npc_reg;
  assign illegal    = illegal_reg;
`ifdef FETCH_TIMEOUT_EN
  assign timeout    = timeout_reg;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_z80_fetch_sequencer.sv
// Scoreboard bench for z80_fetch_sequencer with a small decoder stub and a wait-state memory responder.
// Build with FETCH_TIMEOUT_EN defined to also exercise the read abort path.
`ifndef INSN_GROUP_NEED_MORE_BYTES
`define INSN_GROUP_NEED_MORE_BYTES 8'hFE
`endif
`ifndef INSN_GROUP_ILLEGAL_INSTR
`define INSN_GROUP_ILLEGAL_INSTR 8'hFF
`endif

module tb_z80_fetch_sequencer;

  localparam logic [7:0] G_NOP          = 8'h01;
  localparam logic [7:0] G_LD_DD_NN     = 8'h02;
  localparam logic [7:0] G_LD_R_N       = 8'h03;
  localparam logic [7:0] G_LD_DD_IND_NN = 8'h04;
  localparam logic [7:0] G_MORE         = `INSN_GROUP_NEED_MORE_BYTES;
  localparam logic [7:0] G_ILL          = `INSN_GROUP_ILLEGAL_INSTR;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] instr;
    logic [2:0]  len;
    logic [7:0]  grp;
    logic [15:0] npc;
    logic        ill;
    logic        tmo;
    int          lat;
  } exp_t;

  logic        clk, rst, start;
  logic [15:0] pc_in;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic [31:0] dec_instr;
  logic [1:0]  dec_op_len;
  logic [2:0]  dec_len;
  logic [7:0]  dec_group;
  logic        busy, done, illegal, timeout;
  logic [31:0] instr_out;
  logic [2:0]  instr_len;
  logic [7:0]  group_out;
  logic [15:0] next_pc;

  logic [7:0]  mem [0:65535];
  logic [15:0] addr_q[$];
  exp_t        sb[$];
  exp_t        got_e;
  int          n_vec, n_err, cyc, start_cyc, wait_cfg, wait_left;
  bit          in_read, never_ready;

  z80_fetch_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(rst), .start(start), .pc_in(pc_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .dec_instr(dec_instr), .dec_op_len(dec_op_len), .dec_len(dec_len), .dec_group(dec_group),
    .busy(busy), .done(done), .illegal(illegal), .timeout(timeout),
    .instr_out(instr_out), .instr_len(instr_len), .group_out(group_out), .next_pc(next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decoder stub covering only the opcodes used below.
  always_comb begin
    dec_group = G_ILL;
    dec_len   = 3'd1;
    if (dec_op_len == 2'd0) begin
      dec_group = G_MORE;
    end else if (dec_op_len == 2'd1) begin
      case (dec_instr[7:0])
        8'h00:        begin dec_group = G_NOP;      dec_len = 3'd1; end
        8'h21:        begin dec_group = G_LD_DD_NN; dec_len = 3'd3; end
        8'h3E:        begin dec_group = G_LD_R_N;   dec_len = 3'd2; end
        8'hED, 8'hDD: begin dec_group = G_MORE;     dec_len = 3'd1; end
        default:      begin dec_group = G_ILL;      dec_len = 3'd1; end
      endcase
    end else if (dec_instr[15:0] == 16'h4BED) begin
      dec_group = G_LD_DD_IND_NN;
      dec_len   = 3'd4;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: checks every requested address against the expected read order.
  always @(negedge clk) begin
    if (!mem_rd) begin
      in_read   = 1'b0;
      mem_ready = 1'b0;
    end else if (addr_q.size() == 0) begin
      check_val("rd_unexp", {31'd0, mem_rd}, 32'd0);
      mem_ready = 1'b0;
    end else begin
      check_val("rd_addr", {16'd0, mem_addr}, {16'd0, addr_q[0]});
      if (!in_read) begin
        in_read   = 1'b1;
        wait_left = wait_cfg;
      end
      if (never_ready) begin
        mem_ready = 1'b0;
      end else if (wait_left == 0) begin
        mem_ready = 1'b1;
        mem_data  = mem[mem_addr];
        void'(addr_q.pop_front());
        in_read   = 1'b0;
      end else begin
        wait_left--;
        mem_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check_val("done_unexp", {31'd0, done}, 32'd0);
      end else begin
        got_e = sb.pop_front();
        check_val("instr",   instr_out,                got_e.instr);
        check_val("len",     32'(instr_len),           32'(got_e.len));
        check_val("group",   32'(group_out),           32'(got_e.grp));
        check_val("next_pc", 32'(next_pc),             32'(got_e.npc));
        check_val("illegal", 32'(illegal),             32'(got_e.ill));
        check_val("timeout", 32'(timeout),             32'(got_e.tmo));
        check_val("latency", 32'(cyc - start_cyc),     32'(got_e.lat));
        check_val("busy",    32'(busy),                32'd1);
        $display("txn pc=%h instr=%h len=%0d grp=%h npc=%h ill=%0b tmo=%0b lat=%0d",
                 got_e.pc, instr_out, instr_len, group_out, next_pc, illegal, timeout, cyc - start_cyc);
      end
    end
  end

  task automatic chk_reset();
    check_val("rst_mem_rd",  32'(mem_rd),     32'd0);
    check_val("rst_addr",    32'(mem_addr),   32'd0);
    check_val("rst_done",    32'(done),       32'd0);
    check_val("rst_illegal", 32'(illegal),    32'd0);
    check_val("rst_timeout", 32'(timeout),    32'd0);
    check_val("rst_busy",    32'(busy),       32'd0);
    check_val("rst_instr",   instr_out,       32'd0);
    check_val("rst_len",     32'(instr_len),  32'd0);
    check_val("rst_group",   32'(group_out),  32'd0);
    check_val("rst_npc",     32'(next_pc),    32'd0);
    check_val("rst_oplen",   32'(dec_op_len), 32'd0);
  endtask

  task automatic do_fetch(input logic [15:0] pc, input int nb, input logic [31:0] bytes, input int waits,
                          input int elen, input logic [7:0] egrp, input logic eill, input logic etmo,
                          input int eoplen, input int elat, input int poke_at);
    exp_t e;
    e.pc    = pc;
    e.instr = '0;
    for (int i = 0; i < nb; i++) mem[16'(pc + 16'(i))] = bytes[8*i +: 8];
    for (int i = 0; i < elen; i++) begin
      e.instr[8*i +: 8] = bytes[8*i +: 8];
      addr_q.push_back(16'(pc + 16'(i)));
    end
    if (etmo) begin
      addr_q.push_back(pc);
      never_ready = 1'b1;
    end
    e.len = 3'(elen);
    e.grp = egrp;
    e.npc = 16'(pc + 16'(elen));
    e.ill = eill;
    e.tmo = etmo;
    e.lat = elat;
    sb.push_back(e);
    wait_cfg = waits;
    @(posedge clk); #1;
    start = 1'b1; pc_in = pc; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; pc_in = 16'h0555;
    // Extra start pulse landing while busy or in DONE must be ignored.
    if (poke_at > 0) begin
      repeat (poke_at - 1) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      check_val("done_wait", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    never_ready = 1'b0;
    if (etmo) addr_q.delete();
    else check_val("reads_left", 32'(addr_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    check_val("hold_instr", instr_out,         e.instr);
    check_val("hold_len",   32'(instr_len),    32'(e.len));
    check_val("op_len",     32'(dec_op_len),   32'(eoplen));
    check_val("idle_busy",  32'(busy),         32'd0);
    addr_q.delete();
  endtask

  initial begin
    bit found;
    n_vec = 0; n_err = 0; cyc = 0; start_cyc = 0;
    wait_cfg = 0; wait_left = 0; in_read = 1'b0; never_ready = 1'b0;
    rst = 1'b1; start = 1'b0; pc_in = 16'h0; mem_ready = 1'b0; mem_data = 8'h0;
    #12;
    chk_reset();
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    //       pc        nb  bytes          w  len grp             ill  tmo  opl lat poke
    do_fetch(16'h0100, 1, 32'h00000000,   0, 1, G_NOP,          1'b0, 1'b0, 1,  3,  3);
    do_fetch(16'h0200, 3, 32'h00123421,   0, 3, G_LD_DD_NN,     1'b0, 1'b0, 1,  7,  2);
    do_fetch(16'hFFFE, 4, 32'h56784BED,   0, 4, G_LD_DD_IND_NN, 1'b0, 1'b0, 2,  9,  0);
    do_fetch(16'h0400, 1, 32'h000000FF,   0, 1, G_ILL,          1'b1, 1'b0, 1,  3,  0);
    do_fetch(16'h0410, 2, 32'h000000DD,   0, 2, G_ILL,          1'b1, 1'b0, 2,  5,  0);
    do_fetch(16'h0300, 2, 32'h0000553E,   3, 2, G_LD_R_N,       1'b0, 1'b0, 1, 11,  0);

    // Reset in the middle of the second operand read: everything clears, no done follows.
    mem[16'h0500] = 8'h3E; mem[16'h0501] = 8'h55;
    addr_q.push_back(16'h0500); addr_q.push_back(16'h0501);
    wait_cfg = 3;
    @(posedge clk); #1 start = 1'b1; pc_in = 16'h0500;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 16'h0501) found = 1'b1;
    end
    check_val("rst_reach", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset();
    addr_q.delete();
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(negedge clk);
    check_val("rst_idle", 32'(busy), 32'd0);

    do_fetch(16'h0600, 1, 32'h00000000,   0, 1, G_NOP,          1'b0, 1'b0, 1,  3,  0);
`ifdef FETCH_TIMEOUT_EN
    do_fetch(16'h0700, 0, 32'h00000000,   0, 0, G_ILL,          1'b0, 1'b1, 0, 16,  0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/z80_fetch_sequencer.md
Name: z80_fetch_sequencer

Overview:
Sequences opcode and operand fetch for one Z80 instruction. Reads bytes one at a time from the memory port and accumulates them little-endian into a 32-bit buffer. After each byte it consults the external instr_decoder (combinational, instantiated alongside) to decide whether to fetch another byte. It then hands the complete instruction, length and group to the execute stage.

Parameters:
TIMEOUT_CYCLES, 15, max wait cycles per memory read before abort (used only with FETCH_TIMEOUT_EN); 4..255

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin fetch at pc_in; honoured only in IDLE
pc_in  input  16  address of first instruction byte
mem_rd  output  1  memory read request
mem_addr  output  16  read address
mem_data  input  8  read data, valid when mem_ready=1
mem_ready  input  1  read complete this cycle
dec_instr  output  32  to decoder instr; equals instr_out buffer
dec_op_len  output  2  to decoder op_len
dec_len  input  3  from decoder len
dec_group  input  8  from decoder group
busy  output  1  not IDLE
done  output  1  one-cycle pulse: instruction complete
illegal  output  1  valid with done: decoder reported illegal
timeout  output  1  valid with done: fetch aborted (FETCH_TIMEOUT_EN only, else tied 0)
instr_out  output  32  fetched bytes, byte n at [8n+7:8n], unfetched bytes 0
instr_len  output  3  bytes fetched
group_out  output  8  decoder group latched at completion
next_pc  output  16  pc + instr_len, mod 2^16

Behaviour:
- Reset (async, any state): state=IDLE; mem_rd=0, mem_addr=0, done=0, illegal=0, timeout=0, busy=0, instr_out=0, instr_len=0, group_out=0, next_pc=0, dec_op_len=0; internal pc=0, byte_cnt=0, opcode_phase=0. A fetch in progress is abandoned; no done pulse.
- States: IDLE, FETCH, CHECK, DONE.
- IDLE: on start, latch pc=pc_in. Clear instr buffer, byte_cnt=0 and dec_op_len=0. Set opcode_phase=1. Go to FETCH.
- FETCH: mem_rd=1 and mem_addr=pc+byte_cnt (16-bit wrap, 0xFFFF+1 -> 0x0000), both stable until mem_ready.
  - On mem_ready: write mem_data into byte[byte_cnt] and increment byte_cnt. If opcode_phase, also increment dec_op_len. Deassert mem_rd next cycle and go to CHECK.
  - mem_ready while not in FETCH is ignored.
- CHECK (1 cycle; decoder sees registered buffer and op_len):
  - dec_group == `INSN_GROUP_NEED_MORE_BYTES and dec_op_len<2 -> FETCH (still opcode phase).
  - dec_group == `INSN_GROUP_NEED_MORE_BYTES and dec_op_len==2 -> DONE with illegal=1 (guard; op_len never exceeds 2).
  - dec_group == `INSN_GROUP_ILLEGAL_INSTR -> DONE with illegal=1.
  - Otherwise clear opcode_phase. If byte_cnt < dec_len -> FETCH (operand byte, dec_op_len held); else -> DONE.
  - On the transition to DONE, latch group_out=dec_group, instr_len=byte_cnt and next_pc=pc+byte_cnt.
- DONE: done=1 for exactly one cycle, then IDLE. Outputs instr_out, instr_len, group_out, next_pc, illegal and timeout hold until the next start is accepted. illegal and timeout clear on start.
- Latency with zero wait states: done is asserted 3 cycles after the start cycle for a 1-byte instruction; each additional byte adds 2 cycles. Each wait cycle adds 1.
- start while busy: ignored. start in the DONE cycle: ignored; it must be reasserted in IDLE.
- A 4-byte instruction is the maximum; byte_cnt never exceeds 4.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: an 8-bit wait counter clears on entry to FETCH and increments each FETCH cycle without mem_ready. When it reaches TIMEOUT_CYCLES with no mem_ready, mem_rd drops and the block goes to DONE with timeout=1, illegal=0, group_out=`INSN_GROUP_ILLEGAL_INSTR and instr_len=byte_cnt.
- Undefined: no counter; FETCH waits indefinitely; timeout tied 0.

Test Plan:
- pc_in=0x0100, memory[0x0100]=0x00, ready immediate -> one read at 0x0100; done 3 cycles after start; instr_out=0x00000000, instr_len=1, group=NOP, next_pc=0x0101, illegal=0.
- Memory 0x21,0x34,0x12 at 0x0200 -> reads at 0x0200/0x0201/0x0202; dec_op_len stays 1; instr_out=0x00123421, instr_len=3, group=LD_DD_NN, done at cycle 7.
- Memory 0xED,0x4B,0x78,0x56 at 0xFFFE -> reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001; dec_op_len reaches 2; instr_out=0x56784BED, len=4, group=LD_DD_IND_NN, next_pc=0x0002.
- Byte 0xFF, then separately 0xDD,0x00 -> done with illegal=1, len 1 and len 2 respectively, group=ILLEGAL_INSTR.
- mem_ready delayed 3 cycles on every byte of 0x3E,0x55 -> mem_rd and mem_addr held stable through the waits; done at cycle 11; instr_out=0x0000553E. Assert reset during the second FETCH -> all outputs 0, state IDLE, no done pulse.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, mem_ready never asserted -> mem_rd high for 15 cycles, then done=1, timeout=1, instr_len=0.
